dac_sample_sequencer: RTL

Sample-rate scheduler that sits in front of the 16-bit SPI DAC serializer. Accepts 12-bit samples from two channel sources (A and B) over valid/ready handshakes, once per sample period. Formats each sample into a 16-bit DAC command word. Issues the two words back to back on the serializer's single-cycle write strobe, spaced so that the serializer is never written while it is shifting.

---
 rtl/dac_sample_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dac_sample_sequencer.sv
// Sample-period scheduler: captures coherent A/B samples once per period and issues two spaced DAC command writes.
// Optional saturating underrun counter port enabled by defining DAC_SEQ_UNDERRUN_CNT_EN.
module dac_sample_sequencer #(
  parameter int DIV  = 1024,
  parameter int GAP  = 18,
  parameter int BUF  = 1,
  parameter int GA_N = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] a_data,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [11:0] b_data,
  input  logic        b_valid,
  output logic        b_ready,
  output logic        dac_wr,
  output logic [15:0] dac_wr_data,
  output logic [1:0]  underrun,
  output logic        busy
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
  ,
  output logic [7:0]  underrun_count
`endif
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {IDLE, SEND_A, GAP_A, SEND_B, GAP_B} state_t;

  state_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [11:0]  a_hold_q, a_hold_d;
  logic [11:0]  b_hold_q, b_hold_d;
  logic         dac_wr_q, dac_wr_d;
  logic [15:0]  dac_wr_data_q, dac_wr_data_d;
  logic [1:0]   underrun_q, underrun_d;
  logic         tick;
  logic         accept;

  assign tick   = enable && (cnt_q == CW'(DIV - 1));
  assign accept = (state_q == IDLE) && tick;

  assign a_ready     = accept;
  assign b_ready     = accept;
  assign busy        = (state_q != IDLE);
  assign dac_wr      = dac_wr_q;
  assign dac_wr_data = dac_wr_data_q;
  assign underrun    = underrun_q;

  always_comb begin
    cnt_d = '0;
    if (enable && (cnt_q != CW'(DIV - 1))) cnt_d = cnt_q + 1'b1;
  end

  // Both holds update in the same tick cycle so the pair stays coherent.
  always_comb begin
    a_hold_d   = a_hold_q;
    b_hold_d   = b_hold_q;
    underrun_d = '0;
    if (accept) begin
      if (a_valid) a_hold_d = a_data;
      else         underrun_d[0] = 1'b1;
      if (b_valid) b_hold_d = b_data;
      else         underrun_d[1] = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    dac_wr_d      = 1'b0;
    dac_wr_data_d = dac_wr_data_q;
    case (state_q)
      IDLE: if (tick) state_d = SEND_A;
      SEND_A: begin
        dac_wr_d      = 1'b1;
        dac_wr_data_d = {1'b0, 1'(BUF), 1'(GA_N), 1'b1, a_hold_q};
        gap_d         = '0;
        state_d       = GAP_A;
      end
      GAP_A: begin
        if (gap_q == GW'(GAP - 2)) begin
          gap_d   = '0;
          state_d = SEND_B;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      SEND_B: begin
        dac_wr_d      = 1'b1;
        dac_wr_data_d = {1'b1, 1'(BUF), 1'(GA_N), 1'b1, b_hold_q};
        gap_d         = '0;
        state_d       = GAP_B;
      end
      GAP_B: begin
        if (gap_q == GW'(GAP - 2)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      gap_q         <= '0;
      a_hold_q      <= 12'h800;
      b_hold_q      <= 12'h800;
      dac_wr_q      <= 1'b0;
      dac_wr_data_q <= '0;
      underrun_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      a_hold_q      <= a_hold_d;
      b_hold_q      <= b_hold_d;
      dac_wr_q      <= dac_wr_d;
      dac_wr_data_q <= dac_wr_data_d;
      underrun_q    <= underrun_d;
    end
  end

`ifdef DAC_SEQ_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;
  logic [8:0] ucnt_sum;

  assign ucnt_sum       = {1'b0, ucnt_q} + 9'(underrun_q[0]) + 9'(underrun_q[1]);
  assign underrun_count = ucnt_q;

  always_comb begin
    ucnt_d = '0;
    if (enable) ucnt_d = ucnt_sum[8] ? 8'hFF : ucnt_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end
`endif

endmodule
